// File: rtl/decode_stage.sv
// decode_stage: instruction-decode stage of the 16-bit pipelined processor.
//
// Takes instruction words from fetch, decodes them into register-file
// addresses and EX-stage control, and registers the result.  Two-word LDM
// instructions are assembled here (opcode word, then immediate word).
// A one-cycle bubble is inserted when a word reads the destination of the
// LDD issued in the previous cycle.
//
// Ports:
//   clk, reset            clock (posedge), synchronous active-high reset
//   if_valid/if_instr/if_pc   word offered by fetch
//   if_ready              word consumed this cycle (combinational)
//   ex_stall              hold all outputs and internal state
//   flush                 discard in-flight decode, including a pending LDM
//   id_valid ... illegal  registered decode results for RF / EX
//
// state    | meaning
// ---------+-------------------------------------------
// S_DECODE | normal decode of one word per cycle
// S_IMM    | LDM opcode seen, waiting for its immediate
module decode_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic              if_ready,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              id_valid,
    output logic [REG_AW-1:0] read_addr1,
    output logic [REG_AW-1:0] read_addr2,
    output logic [REG_AW-1:0] write_addr,
    output logic              one_operand,
    output logic              mem_write,
    output logic              mem_read,
    output logic              reg_write,
    output logic              is_ldm,
    output logic [DATA_W-1:0] imm,
    output logic [1:0]        func,
    output logic              is_branch,
    output logic [DATA_W-1:0] pc_out,
    output logic              illegal
);

    localparam logic [0:0] S_DECODE = 1'b0;
    localparam logic [0:0] S_IMM    = 1'b1;

    logic [0:0]        state, state_nxt;
    logic              ld_valid, ld_valid_nxt;
    logic [REG_AW-1:0] ld_rd, ld_rd_nxt;
    logic [REG_AW-1:0] ldm_rd, ldm_rd_nxt;
    logic [DATA_W-1:0] ldm_pc, ldm_pc_nxt;

    logic [2:0]        cls;
    logic [1:0]        fn;
    logic [REG_AW-1:0] rdst, rs1, rs2;
    logic              uses_rs1, uses_rs2, hazard, accept;

    logic              id_valid_n, one_n, mw_n, mr_n, rw_n, ldm_n, br_n, ill_n;
    logic [REG_AW-1:0] ra1_n, ra2_n, wa_n;
    logic [DATA_W-1:0] imm_n, pc_n;
    logic [1:0]        func_n;

    assign cls  = if_instr[15:13];
    assign fn   = if_instr[12:11];
    assign rdst = if_instr[10:8];
    assign rs1  = if_instr[7:5];
    assign rs2  = if_instr[4:2];

    // Only sources the instruction really reads can create a load-use hazard.
    assign uses_rs1 = (cls == 3'b000 && fn != 2'b00) || cls == 3'b001 ||
                      cls == 3'b011 || cls == 3'b100 || cls == 3'b101;
    assign uses_rs2 = cls == 3'b001 || cls == 3'b100;

    // The LDM immediate word is data, never checked for hazards.
    assign hazard = state == S_DECODE && ld_valid && if_valid &&
                    ((uses_rs1 && rs1 == ld_rd) || (uses_rs2 && rs2 == ld_rd));

    assign if_ready = !reset && !flush && !ex_stall && !hazard;
    assign accept   = if_valid && if_ready;

    // Next output bundle for a non-stalled cycle; defaults describe a bubble.
    always_comb begin
        id_valid_n   = 1'b0;
        ra1_n        = '0;
        ra2_n        = '0;
        wa_n         = '0;
        one_n        = 1'b0;
        mw_n         = 1'b0;
        mr_n         = 1'b0;
        rw_n         = 1'b0;
        ldm_n        = 1'b0;
        imm_n        = '0;
        func_n       = 2'b00;
        br_n         = 1'b0;
        ill_n        = 1'b0;
        pc_n         = pc_out;
        state_nxt    = flush ? S_DECODE : state;
        ld_valid_nxt = 1'b0;
        ld_rd_nxt    = ld_rd;
        ldm_rd_nxt   = ldm_rd;
        ldm_pc_nxt   = ldm_pc;

        if (accept) begin
            if (state == S_IMM) begin
                id_valid_n = 1'b1;
                wa_n       = ldm_rd;
                rw_n       = 1'b1;
                ldm_n      = 1'b1;
                imm_n      = if_instr;
                pc_n       = ldm_pc;
                state_nxt  = S_DECODE;
            end else begin
                case (cls)
                    3'b000: begin
                        id_valid_n = 1'b1;
                        pc_n       = if_pc;
                        if (fn != 2'b00) begin
                            ra1_n  = rs1;
                            wa_n   = rdst;
                            one_n  = 1'b1;
                            rw_n   = 1'b1;
                            func_n = fn;
                        end
                    end
                    3'b001: begin
                        id_valid_n = 1'b1;
                        pc_n       = if_pc;
                        ra1_n      = rs1;
                        ra2_n      = rs2;
                        wa_n       = rdst;
                        rw_n       = 1'b1;
                        func_n     = fn;
                    end
                    3'b010: begin
                        ldm_rd_nxt = rdst;
                        ldm_pc_nxt = if_pc;
                        state_nxt  = S_IMM;
                    end
                    3'b011: begin
                        id_valid_n   = 1'b1;
                        pc_n         = if_pc;
                        ra1_n        = rs1;
                        wa_n         = rdst;
                        mr_n         = 1'b1;
                        rw_n         = 1'b1;
                        ld_valid_nxt = 1'b1;
                        ld_rd_nxt    = rdst;
                    end
                    3'b100: begin
                        id_valid_n = 1'b1;
                        pc_n       = if_pc;
                        ra1_n      = rs1;
                        ra2_n      = rs2;
                        mw_n       = 1'b1;
                    end
                    3'b101: begin
                        id_valid_n = 1'b1;
                        pc_n       = if_pc;
                        ra1_n      = rs1;
                        br_n       = 1'b1;
                    end
                    default: ill_n = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_DECODE;
            ld_valid    <= 1'b0;
            ld_rd       <= '0;
            ldm_rd      <= '0;
            ldm_pc      <= '0;
            id_valid    <= 1'b0;
            read_addr1  <= '0;
            read_addr2  <= '0;
            write_addr  <= '0;
            one_operand <= 1'b0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
            reg_write   <= 1'b0;
            is_ldm      <= 1'b0;
            imm         <= '0;
            func        <= 2'b00;
            is_branch   <= 1'b0;
            pc_out      <= '0;
            illegal     <= 1'b0;
        end else if (flush || !ex_stall) begin
            state       <= state_nxt;
            ld_valid    <= ld_valid_nxt;
            ld_rd       <= ld_rd_nxt;
            ldm_rd      <= ldm_rd_nxt;
            ldm_pc      <= ldm_pc_nxt;
            id_valid    <= id_valid_n;
            read_addr1  <= ra1_n;
            read_addr2  <= ra2_n;
            write_addr  <= wa_n;
            one_operand <= one_n;
            mem_write   <= mw_n;
            mem_read    <= mr_n;
            reg_write   <= rw_n;
            is_ldm      <= ldm_n;
            imm         <= imm_n;
            func        <= func_n;
            is_branch   <= br_n;
            pc_out      <= pc_n;
            illegal     <= ill_n;
        end else begin
            // Stalled: everything holds, but the illegal pulse must not stretch.
            illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage.
// Each driven cycle pushes its expected output record; a monitor pops and
// compares every cycle in which the DUT registers a new output.
module tb_decode_stage;

    typedef struct packed {
        logic        v;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [2:0]  wa;
        logic [6:0]  ctl;   // {one_operand, mem_write, mem_read, reg_write, is_ldm, is_branch, illegal}
        logic [15:0] imm;
        logic [1:0]  fn;
        logic [15:0] pc;
    } rec_t;

    localparam logic [6:0] C_ONE = 7'b1000000;
    localparam logic [6:0] C_MW  = 7'b0100000;
    localparam logic [6:0] C_MR  = 7'b0010000;
    localparam logic [6:0] C_RW  = 7'b0001000;
    localparam logic [6:0] C_LDM = 7'b0000100;
    localparam logic [6:0] C_BR  = 7'b0000010;
    localparam logic [6:0] C_ILL = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [15:0] if_instr = '0;
    logic [15:0] if_pc = '0;
    logic        if_ready;
    logic        ex_stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic [2:0]  read_addr1, read_addr2, write_addr;
    logic        one_operand, mem_write, mem_read, reg_write, is_ldm, is_branch, illegal;
    logic [15:0] imm, pc_out;
    logic [1:0]  func;

    int   total = 0;
    int   bad = 0;
    rec_t expq[$];
    logic armed = 1'b0;
    logic fresh = 1'b0;
    logic done = 1'b0;

    decode_stage dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .ex_stall(ex_stall), .flush(flush),
        .id_valid(id_valid), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .write_addr(write_addr), .one_operand(one_operand), .mem_write(mem_write),
        .mem_read(mem_read), .reg_write(reg_write), .is_ldm(is_ldm), .imm(imm),
        .func(func), .is_branch(is_branch), .pc_out(pc_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(input logic v, input logic [2:0] r1, input logic [2:0] r2,
                                input logic [2:0] wa, input logic [6:0] ctl,
                                input logic [15:0] im, input logic [1:0] fn,
                                input logic [15:0] pc);
        rec_t r;
        r.v = v; r.r1 = r1; r.r2 = r2; r.wa = wa; r.ctl = ctl;
        r.imm = im; r.fn = fn; r.pc = pc;
        return r;
    endfunction

    function automatic rec_t bub(input logic [15:0] pc);
        return mk(1'b0, 3'd0, 3'd0, 3'd0, 7'd0, 16'h0, 2'd0, pc);
    endfunction

    function automatic rec_t actual();
        return mk(id_valid, read_addr1, read_addr2, write_addr,
                  {one_operand, mem_write, mem_read, reg_write, is_ldm, is_branch, illegal},
                  imm, func, pc_out);
    endfunction

    // An edge produces new outputs unless the stage was stalled.
    always @(posedge clk) fresh <= armed && (reset || flush || !ex_stall);

    always @(negedge clk) begin
        if (fresh && !done) begin
            rec_t a, e;
            a = actual();
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL out: unexpected output act=%h, none expected", a);
            end else begin
                e = expq.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL out: act=%h exp=%h", a, e);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                        input logic st, input logic fl, input logic rs,
                        input logic exp_rdy, input logic do_push, input rec_t e,
                        input logic chk_frz, input rec_t frz);
        @(posedge clk);
        #1;
        if (chk_frz) begin
            total++;
            if (actual() !== frz) begin
                bad++;
                $display("FAIL frozen: act=%h exp=%h", actual(), frz);
            end
        end
        if_valid = v; if_instr = ins; if_pc = pc;
        ex_stall = st; flush = fl; reset = rs;
        armed = 1'b1;
        if (do_push) expq.push_back(e);
        #1;
        total++;
        if (if_ready !== exp_rdy) begin
            bad++;
            $display("FAIL if_ready: act=%b exp=%b (instr=%h)", if_ready, exp_rdy, ins);
        end
    endtask

    // Plain cycle helper: no stall, no flush, no reset, expected record pushed.
    task automatic go(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic exp_rdy, input rec_t e);
        step(v, ins, pc, 1'b0, 1'b0, 1'b0, exp_rdy, 1'b1, e, 1'b0, bub(16'h0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rec_t frz;
        frz = mk(1'b1, 3'd1, 3'd2, 3'd3, C_RW, 16'h0, 2'd0, 16'h0050);

        // reset: outputs all zero, nothing consumed
        step(1'b1, 16'h2328, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, bub(16'h0), 1'b0, bub(16'h0));
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, bub(16'h0), 1'b0, bub(16'h0));

        // two-operand, one-operand, NOP
        go(1'b1, 16'h2328, 16'h0010, 1'b1, mk(1'b1, 3'd1, 3'd2, 3'd3, C_RW, 16'h0, 2'd0, 16'h0010));
        go(1'b1, 16'h0CC0, 16'h0012, 1'b1, mk(1'b1, 3'd6, 3'd0, 3'd4, C_ONE | C_RW, 16'h0, 2'd1, 16'h0012));
        go(1'b1, 16'h0000, 16'h0014, 1'b1, mk(1'b1, 3'd0, 3'd0, 3'd0, 7'd0, 16'h0, 2'd0, 16'h0014));

        // LDM: bubble, then issue with first word's PC
        go(1'b1, 16'h4500, 16'h0020, 1'b1, bub(16'h0014));
        go(1'b1, 16'hBEEF, 16'h0022, 1'b1, mk(1'b1, 3'd0, 3'd0, 3'd5, C_RW | C_LDM, 16'hBEEF, 2'd0, 16'h0020));

        // LDD r2 <- [r1], then consumer reading r2 via rsrc2: one bubble
        go(1'b1, 16'h6220, 16'h0030, 1'b1, mk(1'b1, 3'd1, 3'd0, 3'd2, C_MR | C_RW, 16'h0, 2'd0, 16'h0030));
        go(1'b1, 16'h2328, 16'h0032, 1'b0, bub(16'h0030));
        go(1'b1, 16'h2328, 16'h0032, 1'b1, mk(1'b1, 3'd1, 3'd2, 3'd3, C_RW, 16'h0, 2'd0, 16'h0032));

        // LDD then independent consumer (rsrc1=3, rsrc2=4): no bubble; STD, branch
        go(1'b1, 16'h6220, 16'h0040, 1'b1, mk(1'b1, 3'd1, 3'd0, 3'd2, C_MR | C_RW, 16'h0, 2'd0, 16'h0040));
        go(1'b1, 16'h2570, 16'h0042, 1'b1, mk(1'b1, 3'd3, 3'd4, 3'd5, C_RW, 16'h0, 2'd0, 16'h0042));
        go(1'b1, 16'h805C, 16'h0044, 1'b1, mk(1'b1, 3'd2, 3'd7, 3'd0, C_MW, 16'h0, 2'd0, 16'h0044));
        go(1'b1, 16'hA0A0, 16'h0046, 1'b1, mk(1'b1, 3'd5, 3'd0, 3'd0, C_BR, 16'h0, 2'd0, 16'h0046));

        // ex_stall held three cycles: outputs frozen, word held until release
        go(1'b1, 16'h2328, 16'h0050, 1'b1, frz);
        step(1'b1, 16'h2570, 16'h0052, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bub(16'h0), 1'b0, frz);
        step(1'b1, 16'h2570, 16'h0052, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bub(16'h0), 1'b1, frz);
        step(1'b1, 16'h2570, 16'h0052, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bub(16'h0), 1'b1, frz);
        step(1'b1, 16'h2570, 16'h0052, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
             mk(1'b1, 3'd3, 3'd4, 3'd5, C_RW, 16'h0, 2'd0, 16'h0052), 1'b1, frz);

        // LDM first word, then flush: pending LDM dropped
        go(1'b1, 16'h4500, 16'h0060, 1'b1, bub(16'h0052));
        step(1'b1, 16'hBEEF, 16'h0062, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, bub(16'h0052), 1'b0, frz);
        go(1'b1, 16'h2328, 16'h0064, 1'b1, mk(1'b1, 3'd1, 3'd2, 3'd3, C_RW, 16'h0, 2'd0, 16'h0064));

        // reserved opcode: consumed, single-cycle illegal pulse
        go(1'b1, 16'hC000, 16'h0070, 1'b1, mk(1'b0, 3'd0, 3'd0, 3'd0, C_ILL, 16'h0, 2'd0, 16'h0064));
        go(1'b0, 16'h0000, 16'h0072, 1'b1, bub(16'h0064));

        // reset in the middle of an LDM: no issue, back to normal decode
        go(1'b1, 16'h4500, 16'h0080, 1'b1, bub(16'h0064));
        step(1'b1, 16'hBEEF, 16'h0082, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, bub(16'h0), 1'b0, frz);
        go(1'b1, 16'h2328, 16'h0084, 1'b1, mk(1'b1, 3'd1, 3'd2, 3'd3, C_RW, 16'h0, 2'd0, 16'h0084));
        go(1'b0, 16'h0000, 16'h0086, 1'b1, bub(16'h0084));

        @(posedge clk);
        @(negedge clk);
        #1;
        done = 1'b1;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: act=%0d pending exp=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
